mem_banked_ctrl: RTL and testbench

MEM_BANKED_CTRL -- requirements
Module: mem_banked_ctrl

---
 rtl/mem_banked_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_banked_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_banked_ctrl.sv
// Banked memory controller: byte-writable on-chip SRAM with a fully pipelined read
// path, plus an external region reached through a registered request/ack handshake with timeout.
module mem_banked_ctrl #(
  parameter int XLEN           = 32,
  parameter int ADDR_BITS      = 24,
  parameter int SRAM_ADDR_BITS = 14,
  parameter int READ_LATENCY   = 2,
  parameter int EXT_TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_read_en,
  input  logic [XLEN/8-1:0]    mem_write_en,
  input  logic [XLEN-1:0]      mem_write_data,
  output logic                 mem_ready,
  output logic [XLEN-1:0]      mem_read_data,
  output logic                 mem_read_ack,
  output logic                 mem_write_ack,
  output logic [ADDR_BITS-1:0] mem_addr_ack,
  output logic                 mem_error,
  output logic [ADDR_BITS-1:0] ext_addr,
  output logic                 ext_read_en,
  output logic [XLEN/8-1:0]    ext_write_en,
  output logic [XLEN-1:0]      ext_write_data,
  input  logic [XLEN-1:0]      ext_read_data,
  input  logic                 ext_ack
);

  localparam int NB    = XLEN / 8;
  localparam int DEPTH = 1 << SRAM_ADDR_BITS;
  localparam int CW    = (EXT_TIMEOUT < 2) ? 1 : $clog2(EXT_TIMEOUT);

  typedef enum logic [1:0] {IDLE, EXT_WAIT, EXT_DONE} state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [ADDR_BITS-1:0]  ext_addr_q, ext_addr_d;
  logic                  ext_rd_en_q, ext_rd_en_d;
  logic [NB-1:0]         ext_we_q, ext_we_d;
  logic [XLEN-1:0]       ext_wdata_q, ext_wdata_d;
  logic                  ext_is_rd_q, ext_is_rd_d;
  logic [XLEN-1:0]       ext_rdata_q, ext_rdata_d;
  logic                  ext_err_q, ext_err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  err_q, err_d;
  logic                  p_vld_q [READ_LATENCY];
  logic                  p_vld_d [READ_LATENCY];
  logic [XLEN-1:0]       p_dat_q [READ_LATENCY];
  logic [XLEN-1:0]       p_dat_d [READ_LATENCY];
  logic [ADDR_BITS-1:0]  p_adr_q [READ_LATENCY];
  logic [ADDR_BITS-1:0]  p_adr_d [READ_LATENCY];

  logic [XLEN-1:0]           mem [DEPTH];
  logic [SRAM_ADDR_BITS-1:0] sram_idx;
  logic                      accept, is_wr, is_sram, sram_wr, sram_rd, ext_req;
  logic                      pipe_busy, ext_rd_ack;

  assign is_wr    = |mem_write_en;
  assign is_sram  = (mem_addr[ADDR_BITS-1:SRAM_ADDR_BITS] == '0);
  assign sram_idx = mem_addr[SRAM_ADDR_BITS-1:0];
  assign accept   = ready_q && !sync_reset && (mem_read_en || is_wr);
  assign sram_wr  = accept && is_sram && is_wr;
  assign sram_rd  = accept && is_sram && !is_wr;
  assign ext_req  = accept && !is_sram;

  // The last stage may still be presenting an ack; only earlier stages block EXT_DONE.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) pipe_busy = pipe_busy | p_vld_q[i];
  end

  always_comb begin
    state_d     = state_q;
    ext_addr_d  = ext_addr_q;
    ext_rd_en_d = ext_rd_en_q;
    ext_we_d    = ext_we_q;
    ext_wdata_d = ext_wdata_q;
    ext_is_rd_d = ext_is_rd_q;
    ext_rdata_d = ext_rdata_q;
    ext_err_d   = ext_err_q;
    cnt_d       = cnt_q;
    wr_ack_d    = sram_wr;
    err_d       = 1'b0;
    ext_rd_ack  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ext_req) begin
          state_d     = EXT_WAIT;
          ext_addr_d  = mem_addr;
          ext_rd_en_d = !is_wr;
          ext_we_d    = mem_write_en;
          ext_wdata_d = mem_write_data;
          ext_is_rd_d = !is_wr;
          ext_err_d   = 1'b0;
          cnt_d       = '0;
        end
      end
      EXT_WAIT: begin
        if (ext_ack) begin
          ext_rdata_d = ext_read_data;
          ext_rd_en_d = 1'b0;
          ext_we_d    = '0;
          state_d     = EXT_DONE;
        end else if (cnt_q == CW'(EXT_TIMEOUT - 1)) begin
          ext_rdata_d = '0;
          ext_err_d   = 1'b1;
          ext_rd_en_d = 1'b0;
          ext_we_d    = '0;
          state_d     = EXT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXT_DONE: begin
        if (!pipe_busy) begin
          state_d    = IDLE;
          ext_rd_ack = ext_is_rd_q;
          wr_ack_d   = !ext_is_rd_q;
          err_d      = ext_err_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Data/address stages only load on a valid beat so the outputs hold between acks.
    p_vld_d[0] = sram_rd;
    p_dat_d[0] = sram_rd ? mem[sram_idx] : p_dat_q[0];
    p_adr_d[0] = sram_rd ? mem_addr : p_adr_q[0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      p_vld_d[i] = p_vld_q[i-1];
      p_dat_d[i] = p_vld_q[i-1] ? p_dat_q[i-1] : p_dat_q[i];
      p_adr_d[i] = p_vld_q[i-1] ? p_adr_q[i-1] : p_adr_q[i];
    end
    if (ext_rd_ack) begin
      p_vld_d[READ_LATENCY-1] = 1'b1;
      p_dat_d[READ_LATENCY-1] = ext_rdata_q;
      p_adr_d[READ_LATENCY-1] = ext_addr_q;
    end

    ready_d = (state_d == IDLE);

    if (sync_reset) begin
      state_d     = IDLE;
      ready_d     = 1'b0;
      ext_addr_d  = '0;
      ext_rd_en_d = 1'b0;
      ext_we_d    = '0;
      ext_wdata_d = '0;
      ext_is_rd_d = 1'b0;
      ext_rdata_d = '0;
      ext_err_d   = 1'b0;
      cnt_d       = '0;
      wr_ack_d    = 1'b0;
      err_d       = 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        p_vld_d[i] = 1'b0;
        p_dat_d[i] = '0;
        p_adr_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      ext_addr_q  <= '0;
      ext_rd_en_q <= 1'b0;
      ext_we_q    <= '0;
      ext_wdata_q <= '0;
      ext_is_rd_q <= 1'b0;
      ext_rdata_q <= '0;
      ext_err_q   <= 1'b0;
      cnt_q       <= '0;
      wr_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        p_vld_q[i] <= 1'b0;
        p_dat_q[i] <= '0;
        p_adr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      ext_addr_q  <= ext_addr_d;
      ext_rd_en_q <= ext_rd_en_d;
      ext_we_q    <= ext_we_d;
      ext_wdata_q <= ext_wdata_d;
      ext_is_rd_q <= ext_is_rd_d;
      ext_rdata_q <= ext_rdata_d;
      ext_err_q   <= ext_err_d;
      cnt_q       <= cnt_d;
      wr_ack_q    <= wr_ack_d;
      err_q       <= err_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        p_vld_q[i] <= p_vld_d[i];
        p_dat_q[i] <= p_dat_d[i];
        p_adr_q[i] <= p_adr_d[i];
      end
    end
  end

  // Storage has no reset so contents survive both reset sources.
  always_ff @(posedge clk) begin
    if (sram_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_write_en[b]) mem[sram_idx][8*b +: 8] <= mem_write_data[8*b +: 8];
      end
    end
  end

  assign mem_ready      = ready_q;
  assign mem_read_ack   = p_vld_q[READ_LATENCY-1];
  assign mem_read_data  = p_dat_q[READ_LATENCY-1];
  assign mem_addr_ack   = p_adr_q[READ_LATENCY-1];
  assign mem_write_ack  = wr_ack_q;
  assign mem_error      = err_q;
  assign ext_addr       = ext_addr_q;
  assign ext_read_en    = ext_rd_en_q;
  assign ext_write_en   = ext_we_q;
  assign ext_write_data = ext_wdata_q;

endmodule

// File: tb/tb_mem_banked_ctrl.sv
// Self-checking bench for mem_banked_ctrl: SRAM byte writes, pipelined reads,
// external handshake, timeout, ack ordering and both resets.
module tb_mem_banked_ctrl;
  localparam int LAT = 2;
  localparam int TMO = 20;

  logic        clk = 0;
  logic        reset_n, sync_reset;
  logic [23:0] mem_addr;
  logic        mem_read_en;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_write_data;
  logic        mem_ready, mem_read_ack, mem_write_ack, mem_error;
  logic [31:0] mem_read_data;
  logic [23:0] mem_addr_ack, ext_addr;
  logic        ext_read_en;
  logic [3:0]  ext_write_en;
  logic [31:0] ext_write_data, ext_read_data;
  logic        ext_ack;

  mem_banked_ctrl #(.XLEN(32), .ADDR_BITS(24), .SRAM_ADDR_BITS(14),
                    .READ_LATENCY(LAT), .EXT_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data),
    .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack), .mem_addr_ack(mem_addr_ack),
    .mem_error(mem_error), .ext_addr(ext_addr), .ext_read_en(ext_read_en),
    .ext_write_en(ext_write_en), .ext_write_data(ext_write_data),
    .ext_read_data(ext_read_data), .ext_ack(ext_ack));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic [23:0] adr;
    logic        err;
    int          cyc;
  } ack_t;

  ack_t        exp_rd[$];
  ack_t        obs_rd[$];
  ack_t        obs_wr[$];
  logic [31:0] model [logic [23:0]];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_read_ack)  obs_rd.push_back('{mem_read_data, mem_addr_ack, mem_error, cyc});
    if (mem_write_ack) obs_wr.push_back('{32'h0, 24'h0, mem_error, cyc});
  end

  // One request held across one rising edge; SRAM reads push their expectation here.
  task automatic issue(input logic [23:0] a, input logic rd, input logic [3:0] we,
                       input logic [31:0] wd, output int acc);
    logic [31:0] cur;
    mem_addr = a; mem_read_en = rd; mem_write_en = we; mem_write_data = wd;
    @(posedge clk); #1;
    acc = cyc;
    mem_addr = '0; mem_read_en = 0; mem_write_en = '0; mem_write_data = '0;
    if (a < 24'h4000) begin
      if (we != 0) begin
        cur = model.exists(a) ? model[a] : 32'h0;
        for (int b = 0; b < 4; b++) if (we[b]) cur[8*b +: 8] = wd[8*b +: 8];
        model[a] = cur;
      end else if (rd) begin
        exp_rd.push_back('{model[a], a, 1'b0, 0});
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 0; sync_reset = 0; mem_addr = '0; mem_read_en = 0; mem_write_en = '0;
    mem_write_data = '0; ext_read_data = '0; ext_ack = 0;
    #1;
    chk_cnt++; if (mem_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", mem_ready); else pass_cnt++;
    chk_cnt++; if (mem_read_ack !== 1'b0 || mem_write_ack !== 1'b0) $display("FAIL reset_acks: got %b%b expected 00", mem_read_ack, mem_write_ack); else pass_cnt++;
    chk_cnt++; if (ext_read_en !== 1'b0 || ext_write_en !== 4'h0) $display("FAIL reset_strobes: got %b %h expected 0 0", ext_read_en, ext_write_en); else pass_cnt++;
    chk_cnt++; if (mem_read_data !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", mem_read_data); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;
    chk_cnt++; if (mem_ready !== 1'b1) $display("FAIL ready_after_release: got %b expected 1", mem_ready); else pass_cnt++;
  endtask

  task automatic test_byte_write;
    int acc;
    ack_t e, o;
    obs_rd.delete(); obs_wr.delete();
    issue(24'h10, 0, 4'hF, 32'hDEADBEEF, acc);
    chk_cnt++; if (mem_write_ack !== 1'b1) $display("FAIL sram_wr_ack: got %b expected 1", mem_write_ack); else pass_cnt++;
    issue(24'h10, 0, 4'h1, 32'h00000011, acc);
    issue(24'h10, 1, 4'h0, 32'h0, acc);
    for (int k = 0; k < 20 && obs_rd.size() < 1; k++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    chk_cnt++; if (obs_rd.size() != 1) $display("FAIL bw_ack_count: got %0d expected 1", obs_rd.size()); else pass_cnt++;
    if (obs_rd.size() > 0 && exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = obs_rd.pop_front();
      chk_cnt++; if (o.dat !== 32'hDEADBE11 || e.dat !== 32'hDEADBE11) $display("FAIL bw_data: got %h expected %h", o.dat, 32'hDEADBE11); else pass_cnt++;
      chk_cnt++; if (o.adr !== 24'h10) $display("FAIL bw_addr_ack: got %h expected 10", o.adr); else pass_cnt++;
      chk_cnt++; if (o.cyc - acc + 1 != LAT) $display("FAIL bw_latency: got %0d expected %0d", o.cyc - acc + 1, LAT); else pass_cnt++;
    end
    chk_cnt++; if (mem_read_data !== 32'hDEADBE11) $display("FAIL bw_hold: got %h expected deadbe11", mem_read_data); else pass_cnt++;
    exp_rd.delete(); obs_rd.delete();
  endtask

  task automatic test_back_to_back;
    int acc, first;
    ack_t e, o;
    for (int i = 0; i < 8; i++) issue(24'(i), 0, 4'hF, $urandom, acc);
    obs_rd.delete();
    for (int i = 0; i < 8; i++) begin
      issue(24'(i), 1, 4'h0, 32'h0, acc);
      if (i == 0) first = acc;
    end
    for (int k = 0; k < 30 && obs_rd.size() < 8; k++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    chk_cnt++; if (obs_rd.size() != 8) $display("FAIL b2b_count: got %0d expected 8", obs_rd.size()); else pass_cnt++;
    if (obs_rd.size() == 8 && exp_rd.size() == 8) begin
      chk_cnt++; if (obs_rd[0].cyc - first + 1 != LAT) $display("FAIL b2b_latency: got %0d expected %0d", obs_rd[0].cyc - first + 1, LAT); else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
        e = exp_rd[i]; o = obs_rd[i];
        chk_cnt++; if (o.dat !== e.dat || o.adr !== e.adr) $display("FAIL b2b_beat%0d: got %h@%h expected %h@%h", i, o.dat, o.adr, e.dat, e.adr); else pass_cnt++;
        chk_cnt++; if (o.cyc != obs_rd[0].cyc + i) $display("FAIL b2b_consecutive%0d: got cycle %0d expected %0d", i, o.cyc, obs_rd[0].cyc + i); else pass_cnt++;
      end
    end
    exp_rd.delete(); obs_rd.delete();
  endtask

  task automatic test_ext_read;
    int acc, ready_hi;
    ack_t e, o;
    obs_rd.delete();
    issue(24'h4000, 1, 4'h0, 32'h0, acc);
    exp_rd.push_back('{32'h12345678, 24'h4000, 1'b0, 0});
    chk_cnt++; if (ext_read_en !== 1'b1 || ext_addr !== 24'h4000 || ext_write_en !== 4'h0) $display("FAIL ext_req: got %b %h %h expected 1 004000 0", ext_read_en, ext_addr, ext_write_en); else pass_cnt++;
    ready_hi = 0;
    repeat (4) begin
      if (mem_ready) ready_hi++;
      @(posedge clk); #1;
    end
    ext_ack = 1; ext_read_data = 32'h12345678;
    @(posedge clk); #1;
    ext_ack = 0; ext_read_data = 32'hFFFFFFFF;
    chk_cnt++; if (ext_read_en !== 1'b0) $display("FAIL ext_strobe_clear: got %b expected 0", ext_read_en); else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (obs_rd.size() != 0) break;
      if (mem_ready) ready_hi++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++; if (ready_hi != 0) $display("FAIL ext_ready_low: got %0d ready cycles expected 0", ready_hi); else pass_cnt++;
    chk_cnt++; if (obs_rd.size() != 1) $display("FAIL ext_ack_count: got %0d expected 1", obs_rd.size()); else pass_cnt++;
    if (obs_rd.size() > 0 && exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = obs_rd.pop_front();
      chk_cnt++; if (o.dat !== e.dat || o.adr !== e.adr || o.err !== e.err) $display("FAIL ext_read: got %h@%h err %b expected %h@%h err %b", o.dat, o.adr, o.err, e.dat, e.adr, e.err); else pass_cnt++;
    end
    exp_rd.delete(); obs_rd.delete();
  endtask

  task automatic test_ext_write;
    int acc;
    obs_rd.delete(); obs_wr.delete();
    issue(24'h5000, 0, 4'h3, 32'hCAFEF00D, acc);
    chk_cnt++; if (ext_write_en !== 4'h3 || ext_write_data !== 32'hCAFEF00D || ext_read_en !== 1'b0) $display("FAIL ext_wr_req: got %h %h %b expected 3 cafef00d 0", ext_write_en, ext_write_data, ext_read_en); else pass_cnt++;
    @(posedge clk); #1;
    ext_ack = 1;
    @(posedge clk); #1;
    ext_ack = 0;
    for (int k = 0; k < 20 && obs_wr.size() < 1; k++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    chk_cnt++; if (obs_wr.size() != 1 || obs_rd.size() != 0) $display("FAIL ext_wr_ack: got %0d wr %0d rd expected 1 wr 0 rd", obs_wr.size(), obs_rd.size()); else pass_cnt++;
    if (obs_wr.size() > 0) begin
      chk_cnt++; if (obs_wr[0].err !== 1'b0) $display("FAIL ext_wr_err: got %b expected 0", obs_wr[0].err); else pass_cnt++;
    end
    obs_wr.delete();
  endtask

  task automatic test_timeout;
    int acc, hi;
    ack_t o;
    obs_rd.delete();
    ext_read_data = 32'h55AA55AA;
    issue(24'h8000, 1, 4'h0, 32'h0, acc);
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      if (!ext_read_en) break;
      hi++;
      @(posedge clk); #1;
    end
    chk_cnt++; if (hi != TMO) $display("FAIL tmo_strobe_cycles: got %0d expected %0d", hi, TMO); else pass_cnt++;
    for (int k = 0; k < 20 && obs_rd.size() < 1; k++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    chk_cnt++; if (obs_rd.size() != 1) $display("FAIL tmo_ack_count: got %0d expected 1", obs_rd.size()); else pass_cnt++;
    if (obs_rd.size() > 0) begin
      o = obs_rd.pop_front();
      chk_cnt++; if (o.dat !== 32'h0 || o.err !== 1'b1 || o.adr !== 24'h8000) $display("FAIL tmo_ack: got %h@%h err %b expected 00000000@008000 err 1", o.dat, o.adr, o.err); else pass_cnt++;
    end
    ext_read_data = 32'h0;
    obs_rd.delete();
  endtask

  task automatic test_order;
    int acc;
    obs_rd.delete(); exp_rd.delete();
    issue(24'h3, 1, 4'h0, 32'h0, acc);
    issue(24'h4001, 1, 4'h0, 32'h0, acc);
    exp_rd.push_back('{32'hA5A55A5A, 24'h4001, 1'b0, 0});
    ext_ack = 1; ext_read_data = 32'hA5A55A5A;
    @(posedge clk); #1;
    ext_ack = 0; ext_read_data = 32'h0;
    for (int k = 0; k < 20 && obs_rd.size() < 2; k++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    chk_cnt++; if (obs_rd.size() != 2) $display("FAIL order_count: got %0d expected 2", obs_rd.size()); else pass_cnt++;
    if (obs_rd.size() == 2 && exp_rd.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        chk_cnt++; if (obs_rd[i].dat !== exp_rd[i].dat || obs_rd[i].adr !== exp_rd[i].adr) $display("FAIL order_ack%0d: got %h@%h expected %h@%h", i, obs_rd[i].dat, obs_rd[i].adr, exp_rd[i].dat, exp_rd[i].adr); else pass_cnt++;
      end
      chk_cnt++; if (obs_rd[1].cyc <= obs_rd[0].cyc) $display("FAIL order_separate: got cycles %0d,%0d expected increasing", obs_rd[0].cyc, obs_rd[1].cyc); else pass_cnt++;
    end
    exp_rd.delete(); obs_rd.delete();
  endtask

  task automatic test_reset_ext;
    int acc;
    ack_t o;
    obs_rd.delete(); obs_wr.delete(); exp_rd.delete();
    issue(24'h6000, 1, 4'h0, 32'h0, acc);
    @(posedge clk); #1;
    chk_cnt++; if (ext_read_en !== 1'b1) $display("FAIL arst_pre_strobe: got %b expected 1", ext_read_en); else pass_cnt++;
    reset_n = 0;
    #1;
    chk_cnt++; if (ext_read_en !== 1'b0 || mem_ready !== 1'b0) $display("FAIL arst_immediate: got strobe %b ready %b expected 0 0", ext_read_en, mem_ready); else pass_cnt++;
    @(posedge clk); #1;
    reset_n = 1;
    ext_ack = 1; ext_read_data = 32'h77777777;
    repeat (3) @(posedge clk);
    #1;
    ext_ack = 0;
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++; if (obs_rd.size() != 0 || obs_wr.size() != 0 || mem_ready !== 1'b1) $display("FAIL arst_no_ack: got %0d rd %0d wr ready %b expected 0 0 1", obs_rd.size(), obs_wr.size(), mem_ready); else pass_cnt++;

    issue(24'h7000, 1, 4'h0, 32'h0, acc);
    sync_reset = 1;
    @(posedge clk); #1;
    sync_reset = 0;
    chk_cnt++; if (ext_read_en !== 1'b0 || mem_ready !== 1'b0) $display("FAIL srst_effect: got strobe %b ready %b expected 0 0", ext_read_en, mem_ready); else pass_cnt++;
    ext_ack = 1;
    @(posedge clk); #1;
    ext_ack = 0;
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++; if (obs_rd.size() != 0 || obs_wr.size() != 0) $display("FAIL srst_no_ack: got %0d rd %0d wr expected 0 0", obs_rd.size(), obs_wr.size()); else pass_cnt++;

    issue(24'h10, 1, 4'h0, 32'h0, acc);
    for (int k = 0; k < 20 && obs_rd.size() < 1; k++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    chk_cnt++; if (obs_rd.size() != 1) $display("FAIL retain_count: got %0d expected 1", obs_rd.size()); else pass_cnt++;
    if (obs_rd.size() > 0) begin
      o = obs_rd.pop_front();
      chk_cnt++; if (o.dat !== 32'hDEADBE11) $display("FAIL retain_data: got %h expected deadbe11", o.dat); else pass_cnt++;
    end
    exp_rd.delete(); obs_rd.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_write();
    test_back_to_back();
    test_ext_read();
    test_ext_write();
    test_timeout();
    test_order();
    test_reset_ext();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
